// File: rtl/bus_slave_port.sv
// Serial-to-parallel bus slave: shifts in an LSB-first address and write data,
// strobes local memory, and streams read data back to the master LSB-first.
module bus_slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_valid,
    input  logic                  m_wdata,
    input  logic                  m_mode,
    output logic                  s_ready,
    output logic                  s_rvalid,
    output logic                  s_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(MAXW + 1);
    // Address bit 0 arrives in IDLE, so ADDR only counts the remaining bits.
    localparam int ALAST = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 2 : 0;
    localparam int DLAST = DATA_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        MEMWR,
        MEMRD,
        RDATA
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] addr_shift;
    logic [DATA_WIDTH-1:0] wdata_shift;
    logic                  addr_last;
    logic                  data_last;
    logic                  bit_adv;

    assign addr_shift  = (addr_q >> 1) | (ADDR_WIDTH'(m_wdata) << (ADDR_WIDTH - 1));
    assign wdata_shift = (wdata_q >> 1) | (DATA_WIDTH'(m_wdata) << (DATA_WIDTH - 1));

    assign addr_last = (cnt == CW'(ALAST));
    assign data_last = (cnt == CW'(DLAST));

    assign bit_adv = (((state == ADDR) || (state == WDATA)) && m_valid)
                   || (state == RDATA);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (m_valid) begin
                    if (ADDR_WIDTH == 1) begin
                        state_nxt = m_mode ? WDATA : MEMRD;
                    end else begin
                        state_nxt = ADDR;
                    end
                end
            end
            ADDR: begin
                if (m_valid && addr_last) begin
                    state_nxt = mode_q ? WDATA : MEMRD;
                end
            end
            WDATA: begin
                if (m_valid && data_last) begin
                    state_nxt = MEMWR;
                end
            end
            MEMWR: state_nxt = IDLE;
            MEMRD: begin
                if (mem_rvalid) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                if (data_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mode_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            s_ready  <= 1'b1;
            s_rvalid <= 1'b0;
            mem_wen  <= 1'b0;
            mem_ren  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state) begin
                cnt <= '0;
            end else if (bit_adv) begin
                cnt <= cnt + 1'b1;
            end

            if (state == IDLE && m_valid) begin
                mode_q <= m_mode;
            end

            if ((state == IDLE || state == ADDR) && m_valid) begin
                addr_q <= addr_shift;
            end

            if (state == WDATA && m_valid) begin
                wdata_q <= wdata_shift;
            end

            // Read data is shifted right so bit 0 always drives s_rdata.
            if (state == MEMRD && mem_rvalid) begin
                rdata_q <= mem_rdata;
            end else if (state == RDATA) begin
                rdata_q <= rdata_q >> 1;
            end

            s_ready  <= (state_nxt == IDLE);
            s_rvalid <= (state_nxt == RDATA);
            mem_wen  <= (state_nxt == MEMWR);
            mem_ren  <= (state_nxt == MEMRD) && (state != MEMRD);
        end
    end

    assign s_rdata   = s_rvalid & rdata_q[0];
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed bench for bus_slave_port: a transaction table plus hand-written
// reset-abort sequence, with a small memory responder and strobe monitor.
module tb_bus_slave_port;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m_valid;
    logic          m_wdata;
    logic          m_mode;
    logic          s_ready;
    logic          s_rvalid;
    logic          s_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen;
    logic          mem_ren;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rvalid = 1'b0;

    bus_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_valid    (m_valid),
        .m_wdata    (m_wdata),
        .m_mode     (m_mode),
        .s_ready    (s_ready),
        .s_rvalid   (s_rvalid),
        .s_rdata    (s_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder and strobe monitor
    int            wen_cnt = 0;
    int            ren_cnt = 0;
    int            both_cnt = 0;
    logic [AW-1:0] wen_addr = '0;
    logic [DW-1:0] wen_data = '0;
    logic [AW-1:0] ren_addr = '0;
    int            lat = 0;
    logic [DW-1:0] rd_val = '0;
    bit            pend = 1'b0;
    int            left = 0;

    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        mem_rdata  = ~rd_val;
        if (mem_wen) begin
            wen_cnt++;
            wen_addr = mem_addr;
            wen_data = mem_wdata;
        end
        if (mem_ren) begin
            ren_cnt++;
            ren_addr = mem_addr;
            pend = 1'b1;
            left = lat;
        end
        if (mem_wen && mem_ren) both_cnt++;
        if (pend) begin
            if (left == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_val;
                pend = 1'b0;
            end else begin
                left--;
            end
        end
    end

    typedef struct {
        bit          mode;
        bit [AW-1:0] addr;
        bit [DW-1:0] data;     // write data, or memory read response
        bit          gap;
        int          lat;
        bit          hold;     // keep m_valid high through the read phases
        bit [AW-1:0] exp_addr;
        bit [DW-1:0] exp_data; // strobed write data, or s_rdata stream
        int          exp_wait; // negedges from mem_ren to first s_rvalid
    } vec_t;

    vec_t vecs[7];
    vec_t rst_vec;

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, int'(s_ready), 1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int            bw;
        int            br;
        int            w;
        int            rv;
        logic [DW-1:0] got;
        bw = wen_cnt;
        br = ren_cnt;
        lat = v.lat;
        rd_val = v.data;
        got = '0;
        wait_ready(tag);
        for (int i = 0; i < AW; i++) begin
            if (i > 0) @(negedge clk);
            m_valid = 1'b1;
            m_wdata = v.addr[i];
            m_mode  = (i == 0) ? v.mode : ~v.mode;
            if (v.gap && (v.mode || i < AW - 1)) begin
                @(negedge clk);
                m_valid = 1'b0;
                m_wdata = ~m_wdata;
            end
        end
        if (v.mode) begin
            for (int i = 0; i < DW; i++) begin
                @(negedge clk);
                m_valid = 1'b1;
                m_wdata = v.data[i];
                if (v.gap && i < DW - 1) begin
                    @(negedge clk);
                    m_valid = 1'b0;
                end
            end
            @(negedge clk);
            m_valid = 1'b0;
            chk({tag, "_wen_hi"}, int'(mem_wen), 1);
            chk({tag, "_ready_lo"}, int'(s_ready), 0);
            @(negedge clk);
            chk({tag, "_wen_lo"}, int'(mem_wen), 0);
            @(negedge clk);
            chk({tag, "_ready_n2"}, int'(s_ready), 1);
            chk({tag, "_wen_cnt"}, wen_cnt - bw, 1);
            chk({tag, "_ren_cnt"}, ren_cnt - br, 0);
            chk({tag, "_waddr"}, int'(wen_addr), int'(v.exp_addr));
            chk({tag, "_wdata"}, int'(wen_data), int'(v.exp_data));
        end else begin
            @(negedge clk);
            m_valid = v.hold;
            chk({tag, "_ren"}, int'(mem_ren), 1);
            chk({tag, "_raddr"}, int'(mem_addr), int'(v.exp_addr));
            w = 0;
            while (!s_rvalid && w <= 50) begin
                @(negedge clk);
                m_wdata = ~m_wdata;
                w++;
            end
            chk({tag, "_rd_wait"}, w, v.exp_wait);
            rv = 0;
            for (int b = 0; b < DW; b++) begin
                if (s_rvalid) rv++;
                got[b] = s_rdata;
                @(negedge clk);
                m_wdata = ~m_wdata;
            end
            m_valid = 1'b0;
            chk({tag, "_rvalid_len"}, rv, DW);
            chk({tag, "_stream"}, int'(got), int'(v.exp_data));
            chk({tag, "_rvalid_end"}, int'(s_rvalid), 0);
            chk({tag, "_ready_end"}, int'(s_ready), 1);
            chk({tag, "_ren_cnt"}, ren_cnt - br, 1);
            chk({tag, "_wen_cnt"}, wen_cnt - bw, 0);
            if (v.hold) begin
                repeat (3) @(negedge clk);
                chk({tag, "_hold_idle"}, int'(s_ready), 1);
                chk({tag, "_hold_ren"}, ren_cnt - br, 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            w0;
        logic [AW-1:0] abort_addr;

        rst = 1'b1;
        m_valid = 1'b0;
        m_wdata = 1'b0;
        m_mode  = 1'b0;

        //             mode  addr     data   gap  lat hold  exp_addr exp_data wait
        vecs[0] = '{1'b1, 12'h0A5, 8'h3C, 1'b0, 0, 1'b0, 12'h0A5, 8'h3C, 0};
        vecs[1] = '{1'b0, 12'h123, 8'hA7, 1'b0, 3, 1'b0, 12'h123, 8'hA7, 4};
        vecs[2] = '{1'b1, 12'hFFF, 8'h81, 1'b1, 0, 1'b0, 12'hFFF, 8'h81, 0};
        vecs[3] = '{1'b0, 12'h2AA, 8'h55, 1'b0, 0, 1'b0, 12'h2AA, 8'h55, 1};
        vecs[4] = '{1'b0, 12'h456, 8'h0F, 1'b0, 1, 1'b1, 12'h456, 8'h0F, 2};
        vecs[5] = '{1'b1, 12'h800, 8'h01, 1'b0, 0, 1'b0, 12'h800, 8'h01, 0};
        vecs[6] = '{1'b0, 12'h7E1, 8'hC3, 1'b1, 5, 1'b0, 12'h7E1, 8'hC3, 6};
        rst_vec = '{1'b1, 12'h001, 8'hFF, 1'b0, 0, 1'b0, 12'h001, 8'hFF, 0};

        repeat (3) @(negedge clk);
        chk("rst_ready", int'(s_ready), 1);
        chk("rst_rvalid", int'(s_rvalid), 0);
        chk("rst_rdata", int'(s_rdata), 0);
        chk("rst_wen", int'(mem_wen), 0);
        chk("rst_ren", int'(mem_ren), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Abort a write after six address bits
        abort_addr = 12'hABC;
        w0 = wen_cnt;
        wait_ready("abort");
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            m_valid = 1'b1;
            m_wdata = abort_addr[i];
            m_mode  = 1'b1;
        end
        @(negedge clk);
        m_valid = 1'b0;
        chk("abort_busy", int'(s_ready), 0);
        rst = 1'b1;
        #1;
        chk("abort_async_addr", int'(mem_addr), 0);
        @(negedge clk);
        chk("abort_ready", int'(s_ready), 1);
        chk("abort_wen", int'(mem_wen), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_no_strobe", wen_cnt - w0, 0);
        run_vec("after_rst", rst_vec);

        chk("wen_ren_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
